// File: rtl/ste_joyport_scanner_if.sv
// ---------------------------------------------------------------------------
// ste_joyport_scanner_if
//   Signal bundle between the STE enhanced joystick port front end and the
//   logic around it (CPU-side register block, physical pads, clock enable).
//
//   clk_en      : clock enable pacing the sample/settle counters
//   sel_wr      : one-clk strobe, load the select latch from sel_din
//   sel_din     : new select-line value (low byte of the direction register)
//   sel_out     : select lines driven to the port, active-low
//   pad_dir_n   : raw direction pins, asynchronous, active-low
//   pad_fire_n  : raw fire pins, asynchronous, active-low
//   dir_word    : {dir_stable[7:0], sel_out[7:0]}
//   fire_word   : {12'hfff, fire_stable[3:0]}
//   busy        : select-line settle window active
//
//   master : the side that drives strobes/pins and reads the words
//   slave  : the scanner itself
// ---------------------------------------------------------------------------
interface ste_joyport_scanner_if;
  logic        clk_en;
  logic        sel_wr;
  logic [7:0]  sel_din;
  logic [7:0]  sel_out;
  logic [7:0]  pad_dir_n;
  logic [3:0]  pad_fire_n;
  logic [15:0] dir_word;
  logic [15:0] fire_word;
  logic        busy;

  modport master (
    output clk_en, sel_wr, sel_din, pad_dir_n, pad_fire_n,
    input  sel_out, dir_word, fire_word, busy
  );

  modport slave (
    input  clk_en, sel_wr, sel_din, pad_dir_n, pad_fire_n,
    output sel_out, dir_word, fire_word, busy
  );
endinterface

// File: rtl/ste_joyport_scanner.sv
// ---------------------------------------------------------------------------
// ste_joyport_scanner
//   Physical-side front end of the STE enhanced joystick port. Holds the
//   CPU-written select latch, synchronises and debounces the direction and
//   fire pins, and freezes direction sampling while freshly selected lines
//   settle. The finished 16-bit words go straight to the register block.
//
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : ste_joyport_scanner_if.slave (see interface header)
//
//   Parameters
//     SAMPLE_DIV     : clk_en cycles per debounce sample tick (>=1)
//     DEBOUNCE_TICKS : consecutive differing ticks needed to flip a bit (>=1)
//     SETTLE_CYCLES  : clk_en cycles of direction freeze after a select write
// ---------------------------------------------------------------------------
module ste_joyport_scanner #(
  parameter int SAMPLE_DIV     = 16,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SETTLE_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  ste_joyport_scanner_if.slave   bus
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  // Counter value on the tick that completes the debounce run.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]             dir_meta, dir_sync;
  logic [3:0]             fire_meta, fire_sync;
  logic [DIV_W-1:0]       div_cnt;
  logic [SET_W-1:0]       settle_cnt;
  logic [7:0]             sel_q;
  logic [7:0]             dir_stable;
  logic [3:0]             fire_stable;
  logic [7:0][CNT_W-1:0]  dir_cnt;
  logic [3:0][CNT_W-1:0]  fire_cnt;

  logic tick;
  logic busy;
  logic settle_done;

  assign busy        = (state_q == ST_SETTLE);
  assign tick        = bus.clk_en && (div_cnt == DIV_LAST);
  // Last clk_en cycle of the window; a concurrent sel_wr overrides it.
  assign settle_done = busy && bus.clk_en && (settle_cnt == SET_ONE) && !bus.sel_wr;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers, free-running on every clk. Idle pins read high.
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // flops sample the pre-edge values; a blocking '=' here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_meta  <= 8'hff;
      dir_sync  <= 8'hff;
      fire_meta <= 4'hf;
      fire_sync <= 4'hf;
    end else begin
      dir_meta  <= bus.pad_dir_n;
      dir_sync  <= dir_meta;
      fire_meta <= bus.pad_fire_n;
      fire_sync <= fire_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Sample tick divider. Free-running on clk_en; select writes leave its
  // phase alone.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (bus.clk_en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Settle FSM: state register + next-state logic.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before any branch so that no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    if (bus.sel_wr) begin
      state_d = ST_SETTLE;
    end else if (settle_done) begin
      state_d = ST_IDLE;
    end
  end

  // Settle down-counter; reloads on every select write, even mid-window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (bus.sel_wr) begin
      settle_cnt <= SET_LOAD;
    end else if (busy && bus.clk_en) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Select latch: accepted on any clk, independent of clk_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= 8'hff;
    end else if (bus.sel_wr) begin
      sel_q <= bus.sel_din;
    end
  end

  // -------------------------------------------------------------------------
  // Direction debounce. A select write wipes partial runs (they belong to the
  // old selection); window expiry takes a one-shot snapshot of the synced
  // pins; otherwise normal debouncing on ticks outside the window.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_stable <= 8'hff;
      dir_cnt    <= '0;
    end else if (bus.sel_wr) begin
      dir_cnt    <= '0;
    end else if (settle_done) begin
      dir_stable <= dir_sync;
      dir_cnt    <= '0;
    end else if (tick && !busy) begin
      for (int i = 0; i < 8; i++) begin
        if (dir_sync[i] == dir_stable[i]) begin
          dir_cnt[i] <= '0;
        end else if (dir_cnt[i] == DB_LAST) begin
          dir_stable[i] <= dir_sync[i];
          dir_cnt[i]    <= '0;
        end else begin
          dir_cnt[i] <= dir_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fire debounce: same rule, runs regardless of the settle window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_stable <= 4'hf;
      fire_cnt    <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (fire_sync[i] == fire_stable[i]) begin
          fire_cnt[i] <= '0;
        end else if (fire_cnt[i] == DB_LAST) begin
          fire_stable[i] <= fire_sync[i];
          fire_cnt[i]    <= '0;
        end else begin
          fire_cnt[i] <= fire_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Outputs are plain concatenations of registered state.
  assign bus.sel_out   = sel_q;
  assign bus.busy      = busy;
  assign bus.dir_word  = {dir_stable, sel_q};
  assign bus.fire_word = {12'hfff, fire_stable};

endmodule

// File: tb/tb_ste_joyport_scanner.sv
// ---------------------------------------------------------------------------
// tb_ste_joyport_scanner
//   Directed self-checking bench for ste_joyport_scanner with default
//   parameters (SAMPLE_DIV=16, DEBOUNCE_TICKS=4, SETTLE_CYCLES=8).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ste_joyport_scanner;

  logic clk;
  logic reset;

  ste_joyport_scanner_if jp ();

  ste_joyport_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (jp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // One-clk select write; returns at the falling edge after the load edge.
  task automatic sel_write(input logic [7:0] d);
    jp.sel_din = d;
    jp.sel_wr  = 1'b1;
    @(negedge clk);
    jp.sel_wr  = 1'b0;
  endtask

  logic [15:0] seen;
  logic        busy_dropped;
  int          lat;
  logic [7:0]  toggle_vals [5];

  initial begin
    toggle_vals = '{8'h00, 8'h55, 8'haa, 8'hc3, 8'h3c};
    reset         = 1'b1;
    jp.clk_en     = 1'b1;
    jp.sel_wr     = 1'b0;
    jp.sel_din    = 8'h00;
    jp.pad_dir_n  = 8'hff;
    jp.pad_fire_n = 4'hf;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1. Reset state
    check("rst_dir_word",  jp.dir_word,  16'hffff);
    check("rst_fire_word", jp.fire_word, 16'hffff);
    check("rst_busy",      16'(jp.busy), 16'h0000);
    check("rst_sel_out",   16'(jp.sel_out), 16'h00ff);

    // 2a. Fire glitch of 48 clk (3 ticks) must never reach fire_word.
    seen = 16'hffff;
    jp.pad_fire_n = 4'he;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (jp.fire_word != 16'hffff) seen = jp.fire_word;
    end
    jp.pad_fire_n = 4'hf;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (jp.fire_word != 16'hffff) seen = jp.fire_word;
    end
    check("fire_glitch", seen, 16'hffff);

    // 2b. Held fire press: change lands 51..66 clk after the pin edge.
    jp.pad_fire_n = 4'he;
    lat = 0;
    while (lat < 100 && jp.fire_word != 16'hfffe) begin
      @(negedge clk);
      lat++;
    end
    check("fire_hold",   jp.fire_word, 16'hfffe);
    check("fire_lat_ok", 16'(lat >= 51 && lat <= 66), 16'h0001);

    jp.pad_fire_n = 4'hf;
    lat = 0;
    while (lat < 100 && jp.fire_word != 16'hffff) begin
      @(negedge clk);
      lat++;
    end
    check("fire_release", jp.fire_word, 16'hffff);

    // 3. Select write, settle window, forced capture on expiry.
    jp.pad_dir_n = 8'h7f;
    sel_write(8'hfe);
    check("sel_out_fe", 16'(jp.sel_out), 16'h00fe);
    for (int k = 0; k < 8; k++) begin
      check("settle_busy", 16'(jp.busy), 16'h0001);
      check("settle_hold", jp.dir_word, 16'hfffe);
      @(negedge clk);
    end
    check("expire_busy", 16'(jp.busy), 16'h0000);
    check("expire_dir",  jp.dir_word,  16'h7ffe);

    // 4. Pin activity during busy is ignored; final synced value captured.
    sel_write(8'hfe);
    for (int k = 0; k < 8; k++) begin
      if (k < 5) jp.pad_dir_n = toggle_vals[k];
      check("toggle_busy", 16'(jp.busy), 16'h0001);
      check("toggle_hold", jp.dir_word, 16'h7ffe);
      @(negedge clk);
    end
    check("toggle_busy_end", 16'(jp.busy), 16'h0000);
    check("toggle_capture",  jp.dir_word,  16'h3cfe);

    // 5. Second write on the exact expiry clk: no capture, fresh window.
    jp.pad_dir_n = 8'h0f;
    sel_write(8'hfe);
    repeat (7) @(negedge clk);
    sel_write(8'hfd);
    check("coll_busy", 16'(jp.busy), 16'h0001);
    check("coll_sel",  16'(jp.sel_out), 16'h00fd);
    check("coll_nocap", jp.dir_word, 16'h3cfd);
    busy_dropped = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (!jp.busy) busy_dropped = 1'b1;
    end
    check("coll_window", 16'(busy_dropped), 16'h0000);
    @(negedge clk);
    check("coll_expire_busy", 16'(jp.busy), 16'h0000);
    check("coll_expire_dir",  jp.dir_word,  16'h0ffd);

    // Normal direction debounce outside the window.
    jp.pad_dir_n = 8'hf0;
    lat = 0;
    while (lat < 100 && jp.dir_word != 16'hf0fd) begin
      @(negedge clk);
      lat++;
    end
    check("dir_debounce", jp.dir_word, 16'hf0fd);
    check("dir_lat_ok",   16'(lat >= 51 && lat <= 66), 16'h0001);

    // 6. clk_en low: nothing paced moves, select still loads, busy holds.
    jp.clk_en     = 1'b0;
    jp.pad_fire_n = 4'h0;
    sel_write(8'ha5);
    seen = 16'hffff;
    busy_dropped = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (jp.fire_word != 16'hffff) seen = jp.fire_word;
      if (!jp.busy) busy_dropped = 1'b1;
    end
    check("noen_fire",     seen, 16'hffff);
    check("noen_busy",     16'(busy_dropped), 16'h0000);
    check("noen_dir_word", jp.dir_word, 16'hf0a5);

    // Asynchronous reset mid-settle, asserted away from any clock edge.
    #2 reset = 1'b1;
    #1;
    check("arst_dir_word",  jp.dir_word,  16'hffff);
    check("arst_fire_word", jp.fire_word, 16'hffff);
    check("arst_busy",      16'(jp.busy), 16'h0000);
    check("arst_sel_out",   16'(jp.sel_out), 16'h00ff);
    @(negedge clk);
    reset         = 1'b0;
    jp.clk_en     = 1'b1;
    jp.pad_fire_n = 4'hf;
    jp.pad_dir_n  = 8'hff;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
